// File: rtl/fetch_redirect_pkg.sv
// Shared constants and fetch-state encoding for the fetch/redirect stage.
// Holds reset PC, NOP encoding and counter width defaults.
package fetch_redirect_pkg;

  localparam logic [31:0] RESETPC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN    = 32'h0000_0000;
  localparam int          CNTW_DEF    = 16;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch PC register and IF/ID latch with redirect (flush) and stall handling.
// All outputs come straight from flops; one-cycle BOOT state suppresses irvalid after reset.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESETPC = RESETPC_DEF,
  parameter int          CNTW    = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     newpc,
  input  logic            pcclear,
  input  logic            pcen,
  input  logic [31:0]     imemdata,
  output logic [31:0]     pc,
  output logic [31:0]     idpc,
  output logic [31:0]     ir,
  output logic            irvalid,
  output logic            misalign,
  output logic [CNTW-1:0] flushsum,
  output logic [CNTW-1:0] stallsum
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  idpc_q, idpc_d;
  logic [31:0]  ir_q, ir_d;
  logic         irvalid_q, irvalid_d;
  logic         misalign_q, misalign_d;
  logic         flush_en;
  logic         stall_en;

  always_comb begin
    state_d    = RUN;
    pc_d       = pc_q;
    idpc_d     = idpc_q;
    ir_d       = ir_q;
    irvalid_d  = irvalid_q;
    misalign_d = misalign_q;

    // A redirect kills the younger fetch even when the hazard unit is stalling.
    if (pcclear) begin
      ir_d      = NOP_INSN;
      idpc_d    = pc_q;
      irvalid_d = 1'b0;
    end else if (pcen) begin
      ir_d      = imemdata;
      idpc_d    = pc_q;
      irvalid_d = (state_q == RUN);
    end

    if (pcen || pcclear) begin
      pc_d = {newpc[31:2], 2'b00};
      if (newpc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESETPC;
      idpc_q     <= RESETPC;
      ir_q       <= NOP_INSN;
      irvalid_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      idpc_q     <= idpc_d;
      ir_q       <= ir_d;
      irvalid_q  <= irvalid_d;
      misalign_q <= misalign_d;
    end
  end

  assign flush_en = pcclear;
  assign stall_en = !pcen && !pcclear;

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (flush_en),
    .cnt (flushsum)
  );

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_en),
    .cnt (stallsum)
  );

  assign pc       = pc_q;
  assign idpc     = idpc_q;
  assign ir       = ir_q;
  assign irvalid  = irvalid_q;
  assign misalign = misalign_q;

endmodule

// File: doc/fetch_redirect.md
FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 Parameter RESETPC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter CNTW, default 16, width of statistic counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 newpc  input  32  next PC computed by npc from this block's pc output.
REQ-006 pcclear  input  1  redirect from npc; taken jump or branch, younger fetched instruction invalid.
REQ-007 pcen  input  1  hazard-unit enable; 0 = stall fetch.
REQ-008 imemdata  input  32  instruction memory read data for address pc, combinational.
REQ-009 pc  output  32  current fetch PC, drives npc and instruction memory address.
REQ-010 idpc  output  32  PC of instruction held in IF/ID.
REQ-011 ir  output  32  instruction held in IF/ID.
REQ-012 irvalid  output  1  IF/ID holds a real instruction, not a bubble.
REQ-013 misalign  output  1  sticky flag, a newpc with nonzero bits [1:0] was accepted.
REQ-014 flushsum  output  CNTW  count of cycles with pcclear=1.
REQ-015 stallsum  output  CNTW  count of cycles with pcen=0 and pcclear=0.

Function
REQ-016 PC update: pc <= {newpc[31:2],2'b00} when pcen=1 or pcclear=1; otherwise hold.
REQ-017 Redirect overrides stall: pcclear=1 with pcen=0 still loads newpc.
REQ-018 IF/ID load (pcen=1, pcclear=0): ir <= imemdata, idpc <= pc, irvalid <= 1.
REQ-019 IF/ID flush (pcclear=1, any pcen): ir <= 32'h00000000, idpc <= pc, irvalid <= 0.
REQ-020 IF/ID stall (pcen=0, pcclear=0): ir, idpc and irvalid hold.
REQ-021 Latency: instruction at address A appears on ir exactly one cycle after pc=A with pcen=1 and pcclear=0.
REQ-022 misalign sets to 1 on any cycle where the PC loads and newpc[1:0]!=0; it clears only on reset.
REQ-023 flushsum increments by 1 each cycle pcclear=1; saturates at all-ones, no wrap.
REQ-024 stallsum increments by 1 each cycle pcen=0 and pcclear=0; saturates at all-ones, no wrap.
REQ-025 Fetch state: two states, BOOT and RUN; BOOT exists only during the cycle after reset deassertion.
REQ-026 In BOOT, irvalid stays 0 and the PC loads per REQ-016; the next state is RUN unconditionally.
REQ-027 In RUN, REQ-016..REQ-024 apply with no further state.
REQ-028 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-029 When rst=1 at a clock edge: pc=RESETPC, idpc=RESETPC, ir=0, irvalid=0, misalign=0, flushsum=0, stallsum=0, state=BOOT.
REQ-030 Reset overrides pcclear, pcen and an in-progress stall or flush; no pending redirect survives reset.

Structure
REQ-031 A shared package holds RESETPC default, NOP encoding 32'h00000000, CNTW default and the BOOT/RUN state encoding.
REQ-032 One sub-module, sat_counter (width-parameterised, synchronous clear, enable, saturating increment), is instantiated twice, for flushsum and stallsum.

Verification
REQ-033 rst=1 for 2 cycles, then release with pcen=1, newpc=pc+4, imemdata=32'h20080001 -> pc=0 after reset, pc=4 one cycle later, irvalid=0 in BOOT, ir=32'h20080001 with idpc=0 on the following edge.
REQ-034 pc=0x10, pcen=0 for 3 cycles -> pc, ir, idpc and irvalid held; stallsum=3.
REQ-035 pc=0x20, pcclear=1, pcen=1, newpc=0x100 for 1 cycle -> pc=0x100, ir=0, irvalid=0, flushsum=1; next normal cycle ir=mem[0x100].
REQ-036 pcclear=1 and pcen=0 together, newpc=0x40 -> pc=0x40, irvalid=0, flushsum increments, stallsum unchanged.
REQ-037 newpc=0x103 accepted -> pc=0x100, misalign=1 and held after further aligned loads; stallsum preloaded to 0xFFFE plus 3 stall cycles -> 0xFFFF.
REQ-038 rst=1 asserted mid-stall with nonzero counters -> every output at its REQ-029 value on the next edge.
